// File: rtl/kgp_input_capture_if.sv
// rtl/kgp_input_capture_if.sv - core-side event read port and display register bus
// master = processor core, slave = capture peripheral.
interface kgp_input_capture_if #(
  parameter int NUM_BTN    = 1,
  parameter int ARR_W      = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_W      = 13
);
  localparam int IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int ENT_W = IDX_W + ARR_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             rd_en;
  logic [ENT_W-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             clr_ovf;
  logic             out_we;
  logic [OUT_W-1:0] out_wdata;
  logic [OUT_W-1:0] out;

  modport master (
    output rd_en, clr_ovf, out_we, out_wdata,
    input  rd_data, empty, full, count, overflow, out
  );

  modport slave (
    input  rd_en, clr_ovf, out_we, out_wdata,
    output rd_data, empty, full, count, overflow, out
  );
endinterface

// File: rtl/kgp_input_capture.sv
// rtl/kgp_input_capture.sv - debounced multi-button input capture with event FIFO
// Each stable button press snapshots the switch array into a show-ahead FIFO.
module kgp_input_capture #(
  parameter int NUM_BTN    = 1,
  parameter int ARR_W      = 5,
  parameter int DB_CYCLES  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_W      = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] button,
  input  logic [ARR_W-1:0]   array,
  kgp_input_capture_if.slave bus
);
  localparam int IDX_W = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int ENT_W = IDX_W + ARR_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int DBW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [NUM_BTN-1:0] btn_s1, btn_s2;
  logic [ARR_W-1:0]   arr_s1, arr_s2;
  logic [NUM_BTN-1:0] stable, stable_d, rise;
  logic [DBW-1:0]     db_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] pending, clr_mask;
  logic [ARR_W-1:0]   snap [NUM_BTN];

  logic               push_valid;
  logic [IDX_W-1:0]   push_idx;
  logic [ENT_W-1:0]   push_data;

  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q, count_nxt;
  logic               empty_q, full_q, ovf_q;
  logic [ENT_W-1:0]   hold_q, rd_data_w;
  logic [OUT_W-1:0]   out_q;
  logic               do_push, do_pop, drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      arr_s1 <= '0;
      arr_s2 <= '0;
    end else begin
      btn_s1 <= button;
      btn_s2 <= btn_s1;
      arr_s1 <= array;
      arr_s2 <= arr_s1;
    end
  end

  // A level change must persist DB_CYCLES consecutive cycles before stable follows it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (btn_s2[i] != stable[i]) begin
          if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
            stable[i] <= ~stable[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign rise = stable & ~stable_d;

  // Lowest pending index wins; the loop runs downward so the last hit is the lowest.
  always_comb begin
    push_valid = 1'b0;
    push_idx   = '0;
    clr_mask   = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) begin
        push_valid  = 1'b1;
        push_idx    = IDX_W'(i);
        clr_mask    = '0;
        clr_mask[i] = 1'b1;
      end
    end
  end

  assign push_data = {push_idx, snap[push_idx]};

  // A fresh press on the same cycle its previous event is pushed stays pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      for (int i = 0; i < NUM_BTN; i++) snap[i] <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | rise;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (rise[i]) snap[i] <= arr_s2;
      end
    end
  end

  assign do_pop    = bus.rd_en & ~empty_q;
  assign do_push   = push_valid & (~full_q | do_pop);
  assign drop      = push_valid & full_q & ~do_pop;
  assign count_nxt = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == CNT_W'(FIFO_DEPTH));
      hold_q  <= rd_data_w;
      if (drop)             ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;
      if (bus.out_we) out_q <= bus.out_wdata;
    end
  end

  // While empty, present the last head value so the core sees a steady read port.
  assign rd_data_w    = empty_q ? hold_q : mem[rd_ptr];
  assign bus.rd_data  = rd_data_w;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.out      = out_q;
endmodule

// File: doc/kgp_input_capture.md
Name: kgp_input_capture

Overview:
- Parametrised input-capture peripheral for the KGP_RISC processor.
- Generalises the single button / 5-bit array input to NUM_BTN buttons and ARR_W-bit switches.
- Per button: synchronises, debounces and edge-detects the input. On each press it snapshots the switch array into a FIFO.
- The core pops captured events through a show-ahead read port. A core-written display register drives the out port.

Parameters:
- NUM_BTN, 1, number of button channels (1..8).
- ARR_W, 5, switch array width.
- DB_CYCLES, 4, consecutive stable cycles required to accept a level change (>=1).
- FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2).
- OUT_W, 13, display register width.
- Derived: IDX_W = max(1, clog2(NUM_BTN)); ENT_W = IDX_W+ARR_W; CNT_W = clog2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- button  in  NUM_BTN  raw asynchronous push buttons.
- array  in  ARR_W  raw switch array.
- rd_en  in  1  pop head entry.
- rd_data  out  ENT_W  head entry {btn_idx, array_snapshot}; show-ahead.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- count  out  CNT_W  entries held, 0..FIFO_DEPTH.
- overflow  out  1  sticky: an event was dropped.
- clr_ovf  in  1  clears overflow.
- out_we  in  1  display write strobe.
- out_wdata  in  OUT_W  display write data.
- out  out  OUT_W  display register.

Behaviour:
- Reset (rst=0, async): sync flops, stable levels, debounce counters, pending bits, FIFO pointers all 0. Outputs: empty=1, full=0, count=0, overflow=0, rd_data=0, out=0.
- Synchroniser: button and array each pass through 2 flops; all later logic uses the synced copies.
- Debounce, per channel:
  - Counter increments while synced button != stable; clears to 0 when they are equal.
  - When the counter reaches DB_CYCLES-1 and they still differ, stable toggles and the counter clears.
  - Glitches shorter than DB_CYCLES cycles never change stable.
- Edge detect: only a stable 0->1 transition is an event. Release (1->0) generates nothing.
  - On the event cycle the channel's pending bit sets and its snap register loads the synced array.
- Arbiter:
  - Each cycle the lowest-index set pending bit is pushed as {idx, snap[idx]} and its pending bit clears.
  - One push per cycle maximum; other pending channels wait.
  - A new event on an already-pending channel overwrites snap; only one entry results.
- FIFO: circular buffer, wrap-around pointers; rd_data = mem[rd_ptr].
  - rd_data is held at its last value when empty=1 and is 0 after reset.
  - rd_en with empty=1 is ignored; no pointer or count change.
  - Push with full=1 and no pop: entry dropped, overflow<=1, pending bit still clears.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only; the pop is ignored.
  - count, empty and full are registered and consistent with the pointers every cycle.
- overflow: clr_ovf clears it. If clr_ovf and a drop occur in the same cycle, the set wins.
- Display: out <= out_wdata on out_we; no other source modifies out.
- Latency: with the FIFO empty and a clean press held, empty falls on exactly the (DB_CYCLES+4)th rising edge after button rises.
  - Edges 1-2 load the synchronizer.
  - Edges 3..(DB_CYCLES+2) run debounce; stable toggles on edge DB_CYCLES+2.
  - Edge DB_CYCLES+3 sets pending.
  - Edge DB_CYCLES+4 pushes.
- Reset mid-operation: all state is discarded immediately, including held entries and pending events.
  - After reset release, a button held high produces one event after the normal latency, because stable restarts at 0.

Test Plan:
- Reset/idle: rst=0 then 1, inputs 0 -> empty=1, count=0, out=0, rd_data=0, overflow=0 for 50 cycles.
- Single press (defaults): array=5'd3, button 0->1 held 200 ns -> empty=0 on 8th edge; rd_data={1'b0,5'd3}. Pulse rd_en -> empty=1, count=0.
- Glitch reject: button high for 3 cycles (DB_CYCLES=4), then low -> no event; count stays 0.
- Multi-channel (NUM_BTN=3): buttons 2 and 0 rise on the same cycle with array=5'd5 -> two entries pushed in order idx 0 then idx 2, both snapshots 5'd5, count=2.
- Overflow: 5 presses with array=1,2,3,4,5, no reads (FIFO_DEPTH=4) -> full=1, count=4, overflow=1. Pops return 1,2,3,4. clr_ovf -> overflow=0.
- Full push+pop and display: with the FIFO full, issue rd_en in the push cycle -> count stays 4, overflow stays 0. out_we with out_wdata=13'h1ABC -> out=13'h1ABC the next cycle. Async reset mid-stream -> all outputs return to reset values.
